// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  localparam int PISO_WIDTH_DEF = 4;

  // Number of serial cycles one word occupies on the line.
  function automatic int piso_frame_len(input int width, input bit par_en);
    return width + int'(par_en);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Loadable bit-position up-counter; saturates at WIDTH-1 and flags it.
module piso_bit_cnt #(
  parameter int WIDTH = 4,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] TC_VAL  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc  = (cnt_q == TC_VAL);
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = '0;
    end else if (inc && !tc) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready input and framed serial output.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_WIDTH_DEF,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pdata,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int          LAST_IDX   = piso_frame_len(WIDTH, PAR_EN) - 1;
  localparam logic [CW:0] LAST_IDX_V = (CW + 1)'(LAST_IDX);
  localparam logic [CW:0] CNT_ONE    = (CW + 1)'(1);

  piso_state_t      state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             so_q, so_d;
  logic             so_valid_q, so_valid_d;
  logic             so_last_q, so_last_d;
  logic             busy_q, busy_d;

  logic             accept_s;
  logic             cnt_ld_s;
  logic             cnt_inc_s;
  logic             cnt_tc_s;
  logic [CW-1:0]    cnt_s;
  logic [CW:0]      cnt_nxt_s;

  logic             load_bit_s;
  logic [WIDTH-1:0] load_rest_s;
  logic             shift_bit_s;
  logic [WIDTH-1:0] shift_rest_s;

`ifdef PISO_PARITY_EN
  logic par_q, par_d;
`endif

  assign in_ready  = (state_q == IDLE) || so_last_q;
  assign accept_s  = in_valid && in_ready;
  assign cnt_nxt_s = {1'b0, cnt_s} + CNT_ONE;

  assign so       = so_q;
  assign so_valid = so_valid_q;
  assign so_last  = so_last_q;
  assign busy     = busy_q;

  piso_bit_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .ld  (cnt_ld_s),
    .inc (cnt_inc_s),
    .cnt (cnt_s),
    .tc  (cnt_tc_s)
  );

  // sr holds the bits still to be sent; so_q already carries the current one.
  always_comb begin
    if (LSB_FIRST) begin
      load_bit_s   = pdata[0];
      load_rest_s  = pdata >> 1'b1;
      shift_bit_s  = sr_q[0];
      shift_rest_s = sr_q >> 1'b1;
    end else begin
      load_bit_s   = pdata[WIDTH-1];
      load_rest_s  = pdata << 1'b1;
      shift_bit_s  = sr_q[WIDTH-1];
      shift_rest_s = sr_q << 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    so_d       = 1'b0;
    so_valid_d = 1'b0;
    so_last_d  = 1'b0;
    busy_d     = 1'b0;
    cnt_ld_s   = 1'b0;
    cnt_inc_s  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d    = SHIFT;
          sr_d       = load_rest_s;
          so_d       = load_bit_s;
          so_valid_d = 1'b1;
          busy_d     = 1'b1;
          cnt_ld_s   = 1'b1;
`ifdef PISO_PARITY_EN
          par_d      = ^pdata;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (!cnt_tc_s) begin
          sr_d       = shift_rest_s;
          so_d       = shift_bit_s;
          so_valid_d = 1'b1;
          busy_d     = 1'b1;
          so_last_d  = (cnt_nxt_s == LAST_IDX_V);
          cnt_inc_s  = 1'b1;
        end else begin
`ifdef PISO_PARITY_EN
          state_d    = PARITY;
          so_d       = par_q;
          so_valid_d = 1'b1;
          so_last_d  = 1'b1;
          busy_d     = 1'b1;
`else
          // Last data bit is on the line: chain straight into the next word if offered.
          if (accept_s) begin
            state_d    = SHIFT;
            sr_d       = load_rest_s;
            so_d       = load_bit_s;
            so_valid_d = 1'b1;
            busy_d     = 1'b1;
            cnt_ld_s   = 1'b1;
          end else begin
            state_d  = IDLE;
            sr_d     = '0;
            cnt_ld_s = 1'b1;
          end
`endif
        end
      end

`ifdef PISO_PARITY_EN
      PARITY: begin
        if (accept_s) begin
          state_d    = SHIFT;
          sr_d       = load_rest_s;
          so_d       = load_bit_s;
          so_valid_d = 1'b1;
          busy_d     = 1'b1;
          cnt_ld_s   = 1'b1;
          par_d      = ^pdata;
        end else begin
          state_d  = IDLE;
          sr_d     = '0;
          cnt_ld_s = 1'b1;
        end
      end
`endif

      default: begin
        state_d  = IDLE;
        sr_d     = '0;
        cnt_ld_s = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      so_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      so_last_q  <= so_last_d;
      busy_q     <= busy_d;
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: MSB-first and LSB-first instances
// share one stimulus stream and are compared with a word/bit-index reference model.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = W + int'(PAR);

  logic         clk;
  logic         rst;
  logic [W-1:0] pdata;
  logic         in_valid;
  logic         in_ready_m, so_m, so_valid_m, so_last_m, busy_m;
  logic         in_ready_l, so_l, so_valid_l, so_last_l, busy_l;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the word in flight and which frame position is on the line.
  bit           m_active;
  logic [W-1:0] m_word;
  int           m_idx;
  bit           acc_flag;

  logic [31:0] rec_m_v, rec_l_v;
  int          rec_n;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .pdata(pdata), .in_valid(in_valid), .in_ready(in_ready_m),
    .so(so_m), .so_valid(so_valid_m), .so_last(so_last_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .pdata(pdata), .in_valid(in_valid), .in_ready(in_ready_l),
    .so(so_l), .so_valid(so_valid_l), .so_last(so_last_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit exp_bit(input bit lsb, input logic [W-1:0] w, input int i);
    if (i >= W) return ^w;
    return lsb ? w[i] : w[W-1-i];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_so_m"}, so_m, 1'b0);
    check_eq({tag, "_vld_m"}, so_valid_m, 1'b0);
    check_eq({tag, "_last_m"}, so_last_m, 1'b0);
    check_eq({tag, "_busy_m"}, busy_m, 1'b0);
    check_eq({tag, "_rdy_m"}, in_ready_m, 1'b1);
    check_eq({tag, "_so_l"}, so_l, 1'b0);
    check_eq({tag, "_busy_l"}, busy_l, 1'b0);
    check_eq({tag, "_rdy_l"}, in_ready_l, 1'b1);
  endtask

  // One clock: check ready, advance the model on the edge, check outputs on the falling edge.
  task automatic cycle();
    bit exp_rdy;
    bit acc;
    bit e_m, e_l, e_last;
    exp_rdy = !m_active || (m_idx == FL - 1);
    check_eq("in_ready_m", in_ready_m, exp_rdy);
    check_eq("in_ready_l", in_ready_l, exp_rdy);
    acc = in_valid && exp_rdy;
    acc_flag = acc;
    @(posedge clk);
    if (m_active && (m_idx < FL - 1)) begin
      m_idx++;
    end else if (acc) begin
      m_active = 1'b1;
      m_word   = pdata;
      m_idx    = 0;
    end else begin
      m_active = 1'b0;
      m_idx    = 0;
    end
    @(negedge clk);
    e_m    = m_active ? exp_bit(1'b0, m_word, m_idx) : 1'b0;
    e_l    = m_active ? exp_bit(1'b1, m_word, m_idx) : 1'b0;
    e_last = m_active && (m_idx == FL - 1);
    check_eq("so_m", so_m, e_m);
    check_eq("so_l", so_l, e_l);
    check_eq("so_valid_m", so_valid_m, m_active);
    check_eq("so_valid_l", so_valid_l, m_active);
    check_eq("so_last_m", so_last_m, e_last);
    check_eq("so_last_l", so_last_l, e_last);
    check_eq("busy_m", busy_m, m_active);
    check_eq("busy_l", busy_l, m_active);
    if (so_valid_m) begin
      rec_m_v = {rec_m_v[30:0], so_m};
      rec_n++;
    end
    if (so_valid_l) rec_l_v = {rec_l_v[30:0], so_l};
  endtask

  task automatic clr_rec();
    rec_m_v = 32'd0;
    rec_l_v = 32'd0;
    rec_n   = 0;
  endtask

  task automatic send(input logic [W-1:0] w, input bit hold_after);
    int n;
    n = 0;
    in_valid = 1'b1;
    pdata    = w;
    acc_flag = 1'b0;
    while (!acc_flag && n < 20) begin
      cycle();
      n++;
    end
    check_eq("accept_seen", acc_flag, 1'b1);
    if (!hold_after) begin
      in_valid = 1'b0;
      pdata    = W'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_active && n < 40) begin
      pdata = W'($urandom);
      cycle();
      n++;
    end
    check_eq("drain_done", m_active, 1'b0);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] exp_m,
                             input logic [31:0] exp_l, input int exp_n);
    check_eq({tag, "_msb_bits"}, rec_m_v, exp_m);
    check_eq({tag, "_lsb_bits"}, rec_l_v, exp_l);
    check_eq({tag, "_nbits"}, rec_n, exp_n);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    pdata    = '0;
    m_active = 1'b0;
    m_word   = '0;
    m_idx    = 0;
    acc_flag = 1'b0;
    clr_rec();

    #1;
    check_idle_outputs("rst_async");
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("rst_hold");
    end
    rst = 1'b0;
    repeat (5) cycle();

    // Single frame of 1011, pdata scrambled once accepted.
    clr_rec();
    send(4'b1011, 1'b0);
    drain();
`ifdef PISO_PARITY_EN
    check_frame("frame_1011", 32'b10111, 32'b11011, 5);
`else
    check_frame("frame_1011", 32'b1011, 32'b1101, 4);
`endif

    // Back-to-back: second word offered while the first is still shifting.
    clr_rec();
    send(4'b1011, 1'b1);
    send(4'b0100, 1'b0);
    drain();
`ifdef PISO_PARITY_EN
    check_frame("b2b", 32'b1011101001, 32'b1101100101, 10);
`else
    check_frame("b2b", 32'hB4, 32'hD2, 8);
`endif

    clr_rec();
    send(4'b0110, 1'b0);
    drain();
`ifdef PISO_PARITY_EN
    check_frame("frame_0110", 32'b01100, 32'b01100, 5);
`else
    check_frame("frame_0110", 32'b0110, 32'b0110, 4);
`endif

    // Reset in the middle of a frame, then a fresh word must go out intact.
    send(4'b1111, 1'b0);
    cycle();
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    m_active = 1'b0;
    m_idx    = 0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst_mid_hold");
    rst = 1'b0;
    clr_rec();
    send(4'b0001, 1'b0);
    drain();
`ifdef PISO_PARITY_EN
    check_frame("post_rst", 32'b00011, 32'b10001, 5);
`else
    check_frame("post_rst", 32'b0001, 32'b1000, 4);
`endif

    // Random traffic: hold a word until it is taken, otherwise draw fresh valid/data.
    acc_flag = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || acc_flag) begin
        in_valid = ($urandom_range(0, 3) != 0);
        pdata    = W'($urandom);
      end
      cycle();
    end
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
